// File: rtl/vend_dispense_scheduler.sv
// vend_dispense_scheduler: round-robin two-panel arbiter sequencing stock check, product motor and change-coin ejection
// Ports: clk/rst (async active-high); req/sel/chg per panel in, gnt/done/rej per panel out (1-cycle pulses);
//        motor_en/motor_sel out with motor_done in; coin_pulse out with coin_ack in; restock in;
//        stock_empty[i] out when product i is sold out; fault out, sticky until rst.
module vend_dispense_scheduler #(
  parameter int NPROD      = 4,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8,
  parameter int CHG_W      = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [1:0]       sel_a,
  input  logic [CHG_W-1:0] chg_a,
  input  logic             req_b,
  input  logic [1:0]       sel_b,
  input  logic [CHG_W-1:0] chg_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic             rej_a,
  output logic             rej_b,
  output logic             motor_en,
  output logic [1:0]       motor_sel,
  input  logic             motor_done,
  output logic             coin_pulse,
  input  logic             coin_ack,
  input  logic             restock,
  output logic [NPROD-1:0] stock_empty,
  output logic             fault
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, CHECK, MOTOR, CHANGE, COIN_WAIT, DONE, FAULT} state_t;
  state_t state, state_n;
  logic own, own_n, ptr, ptr_n, g, d, r, mot_n, coin_n;
  logic [1:0] sel, sel_n;
  logic [CHG_W-1:0] rem, rem_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [STOCK_W-1:0] stock [NPROD];
  logic [STOCK_W-1:0] stock_n [NPROD];
  always_comb begin
    state_n = state;
    own_n   = own;
    ptr_n   = ptr;
    sel_n   = sel;
    rem_n   = rem;
    cnt_n   = cnt;
    stock_n = stock;
    g       = 1'b0;
    d       = 1'b0;
    r       = 1'b0;
    mot_n   = 1'b0;
    coin_n  = 1'b0;
    case (state)
      IDLE:
        if (restock) begin
          for (int i = 0; i < NPROD; i++) stock_n[i] = STOCK_W'(STOCK_INIT);
        end else if ((req_a | req_b) && !(rej_a | rej_b)) begin
          // A panel still sees its own rej pulse this cycle; don't re-grant its stale request.
          own_n   = (req_a & req_b) ? ptr : req_b;
          sel_n   = own_n ? sel_b : sel_a;
          rem_n   = own_n ? chg_b : chg_a;
          state_n = CHECK;
          g       = 1'b1;
        end
      CHECK:
        if (stock[sel] == '0) begin
          state_n = IDLE;
          r       = 1'b1;
          ptr_n   = ~own;
        end else begin
          state_n = MOTOR;
          cnt_n   = '0;
          mot_n   = 1'b1;
        end
      MOTOR:
        if (motor_done) begin
          state_n      = CHANGE;
          stock_n[sel] = (stock[sel] != '0) ? stock[sel] - 1'b1 : '0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_n = FAULT;
        end else begin
          cnt_n = cnt + 1'b1;
          mot_n = 1'b1;
        end
      CHANGE:
        if (rem == '0) begin
          state_n = DONE;
          d       = 1'b1;
        end else begin
          state_n = COIN_WAIT;
          coin_n  = 1'b1;
          cnt_n   = '0;
        end
      COIN_WAIT:
        if (coin_ack) begin
          rem_n   = rem - 1'b1;
          state_n = CHANGE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_n = FAULT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      DONE: begin
        state_n = IDLE;
        ptr_n   = ~own;
      end
      FAULT: state_n = FAULT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      own         <= 1'b0;
      ptr         <= 1'b0;
      sel         <= '0;
      rem         <= '0;
      cnt         <= '0;
      for (int i = 0; i < NPROD; i++) stock[i] <= STOCK_W'(STOCK_INIT);
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      done_a      <= 1'b0;
      done_b      <= 1'b0;
      rej_a       <= 1'b0;
      rej_b       <= 1'b0;
      motor_en    <= 1'b0;
      motor_sel   <= '0;
      coin_pulse  <= 1'b0;
      fault       <= 1'b0;
      stock_empty <= '0;
    end else begin
      state      <= state_n;
      own        <= own_n;
      ptr        <= ptr_n;
      sel        <= sel_n;
      rem        <= rem_n;
      cnt        <= cnt_n;
      stock      <= stock_n;
      gnt_a      <= g & ~own_n;
      gnt_b      <= g & own_n;
      done_a     <= d & ~own;
      done_b     <= d & own;
      rej_a      <= r & ~own;
      rej_b      <= r & own;
      motor_en   <= mot_n;
      motor_sel  <= sel_n;
      coin_pulse <= coin_n;
      fault      <= state_n == FAULT;
      for (int i = 0; i < NPROD; i++) stock_empty[i] <= stock_n[i] == '0;
    end
endmodule

// File: tb/tb_vend_dispense_scheduler.sv
// tb_vend_dispense_scheduler: randomized and directed checks of the dispense scheduler against a transaction-level model
module tb_vend_dispense_scheduler;
  logic clk = 1'b0, rst = 1'b1;
  logic req_a = 0, req_b = 0, motor_done = 0, coin_ack = 0, restock = 0;
  logic [1:0] sel_a = 0, sel_b = 0, motor_sel;
  logic [2:0] chg_a = 0, chg_b = 0;
  logic gnt_a, gnt_b, done_a, done_b, rej_a, rej_b, motor_en, coin_pulse, fault;
  logic [3:0] stock_empty;
  int checks = 0, errors = 0;
  int mstock [4];
  bit mptr;

  always #5 clk = ~clk;

  vend_dispense_scheduler dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .sel_a(sel_a), .chg_a(chg_a),
    .req_b(req_b), .sel_b(sel_b), .chg_b(chg_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .rej_a(rej_a), .rej_b(rej_b),
    .motor_en(motor_en), .motor_sel(motor_sel), .motor_done(motor_done),
    .coin_pulse(coin_pulse), .coin_ack(coin_ack),
    .restock(restock), .stock_empty(stock_empty), .fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] mempty();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = mstock[i] == 0;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    chk("pulse_excl", 32'($countones({gnt_a, gnt_b, done_a, done_b, rej_a, rej_b}) <= 1), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {req_a, req_b, motor_done, coin_ack, restock} = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mstock[i] = 8;
    mptr = 1'b0;
  endtask

  task automatic start(input bit side, input logic [1:0] s, input logic [2:0] c);
    if (side) begin req_b = 1; sel_b = s; chg_b = c; end
    else begin req_a = 1; sel_a = s; chg_a = c; end
  endtask

  task automatic drop(input bit side);
    if (side) req_b = 0; else req_a = 0;
  endtask

  task automatic grant_chk(input bit side);
    chk("gnt_a", 32'(gnt_a), 32'(!side));
    chk("gnt_b", 32'(gnt_b), 32'(side));
  endtask

  // Continues a granted transaction from the CHECK cycle; leaves the DUT in IDLE.
  task automatic finish(input bit side, input logic [1:0] s, input logic [2:0] c, input int ack_dly, input int mot_dly);
    int coins, wait_ack;
    bit got;
    if (mstock[s] == 0) begin
      tick();
      chk("rej", 32'(side ? rej_b : rej_a), 32'd1);
      chk("rej_no_motor", 32'(motor_en), 32'd0);
      drop(side);
      mptr = !side;
    end else begin
      tick();
      chk("motor_en", 32'(motor_en), 32'd1);
      chk("motor_sel", 32'(motor_sel), 32'(s));
      if ($urandom_range(0, 1) == 1) drop(side);
      repeat (mot_dly) tick();
      motor_done = 1;
      tick();
      motor_done = 0;
      chk("motor_off", 32'(motor_en), 32'd0);
      mstock[s]--;
      coins = 0;
      wait_ack = -1;
      got = 0;
      for (int k = 0; k < 300 && !got; k++) begin
        coin_ack = wait_ack == 0;
        if (wait_ack >= 0) wait_ack--;
        tick();
        if (coin_pulse) begin coins++; wait_ack = ack_dly; end
        if (side ? done_b : done_a) got = 1;
      end
      coin_ack = 0;
      chk("done", 32'(got), 32'd1);
      chk("coins", 32'(coins), 32'(c));
      drop(side);
      mptr = !side;
    end
    chk("stock_empty", 32'(stock_empty), 32'(mempty()));
    tick();
  endtask

  task automatic serve(input bit side, input logic [1:0] s, input logic [2:0] c, input int ack_dly, input int mot_dly);
    start(side, s, c);
    tick();
    grant_chk(side);
    finish(side, s, c, ack_dly, mot_dly);
  endtask

  task automatic pair(input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] ca, input logic [2:0] cb);
    bit w;
    start(0, sa, ca);
    start(1, sb, cb);
    tick();
    w = mptr;
    grant_chk(w);
    finish(w, w ? sb : sa, w ? cb : ca, 1, 1);
    tick();
    grant_chk(!w);
    finish(!w, w ? sa : sb, w ? ca : cb, 1, 1);
  endtask

  task automatic do_restock();
    restock = 1;
    tick();
    restock = 0;
    for (int i = 0; i < 4; i++) mstock[i] = 8;
    chk("restock_empty", 32'(stock_empty), 32'd0);
  endtask

  initial begin
    do_reset();
    rst = 1'b1;
    #1;
    chk("rst_outs", 32'({gnt_a, gnt_b, done_a, done_b, rej_a, rej_b, motor_en, coin_pulse, fault}), 32'd0);
    chk("rst_sel", 32'(motor_sel), 32'd0);
    chk("rst_empty", 32'(stock_empty), 32'd0);
    rst = 1'b0;
    tick();
    // Both sides at once: A wins first after reset, B next, then A again.
    pair(2'd0, 2'd3, 3'd0, 3'd0);
    pair(2'd3, 2'd0, 3'd0, 3'd0);
    serve(0, 2'd2, 3'd1, 0, 2);
    for (int i = 0; i < 9; i++) serve(0, 2'd1, 3'd0, 0, $urandom_range(0, 3));
    chk("empty1", 32'(stock_empty[1]), 32'd1);
    do_restock();
    serve(1, 2'd2, 3'd5, 3, 1);
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) do_restock();
      if ($urandom_range(0, 3) == 0)
        pair(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      else
        serve(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              $urandom_range(0, 4), $urandom_range(0, 5));
    end
    // Motor never reports back.
    do_reset();
    start(0, 2'd1, 3'd0);
    tick();
    grant_chk(0);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_motor_en", 32'(motor_en), 32'd1);
      chk("to_no_fault", 32'(fault), 32'd0);
    end
    tick();
    chk("fault", 32'(fault), 32'd1);
    chk("fault_motor", 32'(motor_en), 32'd0);
    drop(0);
    start(1, 2'd0, 3'd0);
    repeat (5) begin
      tick();
      chk("fault_no_gnt", 32'({gnt_a, gnt_b}), 32'd0);
      chk("fault_sticky", 32'(fault), 32'd1);
    end
    drop(1);
    do_reset();
    chk("fault_clr", 32'(fault), 32'd0);
    // Reset while waiting on a coin.
    start(0, 2'd0, 3'd2);
    tick();
    grant_chk(0);
    tick();
    motor_done = 1;
    tick();
    motor_done = 0;
    tick();
    chk("cw_coin", 32'(coin_pulse), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", 32'({gnt_a, gnt_b, done_a, done_b, rej_a, rej_b, motor_en, coin_pulse, fault}), 32'd0);
    chk("async_empty", 32'(stock_empty), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_a = 0;
    for (int i = 0; i < 4; i++) mstock[i] = 8;
    mptr = 1'b0;
    serve(1, 2'd0, 3'd1, 2, 0);
    for (int i = 0; i < 8; i++) serve(1'(i % 2), 2'd0, 3'd0, 0, 0);
    chk("empty0", 32'(stock_empty[0]), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
